// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link (receiver and transmitter sides).
// Contents: frame state enum, data width, line-level constants and a parity helper.
package serial_link_pkg;

  localparam int unsigned DATA_W = 8;

  // Line levels of the framing bits.
  localparam logic IdleLevel = 1'b1;
  localparam logic StartBit  = 1'b0;
  localparam logic StopBit   = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } link_state_e;

  // Parity bit that makes data plus parity even (odd = 0) or odd (odd = 1).
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_rx_frame_if.sv
// Bus between the serial receiver and its line/decoder neighbours.
//   serial_in    : asynchronous serial line, idles high
//   data_out     : last received byte
//   data_valid   : one-cycle strobe when data_out and the error flags update
//   parity_error : parity mismatch on the delivered frame
//   frame_error  : stop bit sampled low on the delivered frame
//   busy         : receiver is inside a frame
// Modports: slave = receiver, master = line driver / byte consumer.
interface serial_rx_frame_if;

  logic                               serial_in;
  logic [serial_link_pkg::DATA_W-1:0] data_out;
  logic                               data_valid;
  logic                               parity_error;
  logic                               frame_error;
  logic                               busy;

  modport master (
    output serial_in,
    input  data_out,
    input  data_valid,
    input  parity_error,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  serial_in,
    output data_out,
    output data_valid,
    output parity_error,
    output frame_error,
    output busy
  );

endinterface

// File: rtl/rx_shift_reg.sv
// Serial-in / parallel-out register for received data, filled LSB first.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   clr_i      : synchronous clear (wins over shift)
//   shift_en_i : shift bit_i in at the MSB end
//   bit_i      : serial data bit
//   data_o     : parallel contents
module rx_shift_reg
  import serial_link_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              shift_en_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q, data_d;

  // Right shift: the first bit received ends up in bit 0 after DATA_W shifts.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (shift_en_i) begin
      data_d = {bit_i, data_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_rx_frame.sv
// Serial frame receiver: start bit 0, 8 data bits LSB first, optional parity, stop bit 1.
// Delivers each byte with a one-cycle data_valid and per-frame error flags.
//   CLK    : clock, rising edge
//   RST_N  : synchronous active-low reset
//   bus_io : serial_rx_frame_if slave (serial_in in; data_out, data_valid,
//            parity_error, frame_error, busy out)
// Build option: define RX_PARITY_EN to receive a parity bit after data bit 7.
module serial_rx_frame
  import serial_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  serial_rx_frame_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  // Input synchronizer and edge history.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q    <= {SYNC_STAGES{IdleLevel}};
      rx_prev_q <= IdleLevel;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus_io.serial_in};
      rx_prev_q <= rx_s;
    end
  end

  link_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d, shift_data;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              par_q, par_d;
  logic              shift_en, shift_clr;

  rx_shift_reg u_shift (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .clr_i      (shift_clr),
    .shift_en_i (shift_en),
    .bit_i      (rx_s),
    .data_o     (shift_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    par_d     = par_q;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Only a genuine 1->0 edge starts a frame, so a held-low line is ignored.
        if (rx_prev_q == IdleLevel && rx_s == StartBit) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (rx_s == StartBit) begin
            state_d   = StData;
            idx_d     = '0;
            shift_clr = 1'b1;
          end else begin
            state_d = StIdle;  // glitch, drop silently
          end
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntFull) begin
          // Frame is delivered even with errors; flags hold until the next frame.
          cnt_d   = '0;
          state_d = StIdle;
          valid_d = 1'b1;
          data_d  = shift_data;
          ferr_d  = (rx_s != StopBit);
`ifdef RX_PARITY_EN
          perr_d  = (parity_bit(shift_data, 1'(PARITY_ODD)) != par_q);
`else
          perr_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      par_q   <= par_d;
    end
  end

`ifndef RX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
`endif

  assign bus_io.data_out     = data_q;
  assign bus_io.data_valid   = valid_q;
  assign bus_io.frame_error  = ferr_q;
  assign bus_io.parity_error = perr_q;
  assign bus_io.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench for serial_rx_frame with CLKS_PER_BIT=4, SYNC_STAGES=2, even parity.
// The parity bit is only put on the line when RX_PARITY_EN is defined for the build.
module tb_serial_rx_frame;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_rx_frame_if bus ();

  serial_rx_frame #(
    .CLKS_PER_BIT (Cpb),
    .PARITY_ODD   (0),
    .SYNC_STAGES  (2)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .bus_io (bus)
  );

  // Pulse monitor: records every data_valid with the values it qualifies.
  int         vcount = 0;
  logic [7:0] cap_data [0:63];
  logic       cap_perr [0:63];
  logic       cap_ferr [0:63];

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1 && vcount < 64) begin
      cap_data[vcount] = bus.data_out;
      cap_perr[vcount] = bus.parity_error;
      cap_ferr[vcount] = bus.frame_error;
      vcount++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    bus.serial_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    hold(1'b0, Cpb);
    for (int i = 0; i < 8; i++) hold(d[i], Cpb);
`ifdef RX_PARITY_EN
    hold(par, Cpb);
`endif
    hold(stop, Cpb);
  endtask

  int   base;
  int   busy_cycles;
  logic exp_perr_01;

  initial begin
`ifdef RX_PARITY_EN
    exp_perr_01 = 1'b1;
`else
    exp_perr_01 = 1'b0;
`endif
    bus.serial_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_perr", bus.parity_error, 1'b0);
    check("rst_ferr", bus.frame_error, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 4);

    // 0xA5, correct even parity 0.
    base = vcount;
    send_frame(8'hA5, 1'b0, 1'b1);
    hold(1'b1, 6);
    check("a5_pulses", vcount - base, 1);
    check("a5_data", cap_data[base], 8'hA5);
    check("a5_perr", cap_perr[base], 1'b0);
    check("a5_ferr", cap_ferr[base], 1'b0);
    check("a5_busy", bus.busy, 1'b0);
    check("a5_held", bus.data_out, 8'hA5);

    // 0x01 with parity 0: wrong for even parity.
    base = vcount;
    send_frame(8'h01, 1'b0, 1'b1);
    hold(1'b1, 6);
    check("p01_pulses", vcount - base, 1);
    check("p01_data", cap_data[base], 8'h01);
    check("p01_perr", cap_perr[base], exp_perr_01);
    check("p01_ferr", cap_ferr[base], 1'b0);

    // 0x3C with stop bit 0, then the line held low.
    base = vcount;
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 40);
    check("brk_pulses", vcount - base, 1);
    check("brk_data", cap_data[base], 8'h3C);
    check("brk_ferr", cap_ferr[base], 1'b1);
    check("brk_perr", cap_perr[base], 1'b0);
    check("brk_busy", bus.busy, 1'b0);
    hold(1'b1, 8);
    check("brk_no_more", vcount - base, 1);
    check("brk_flag_held", bus.frame_error, 1'b1);

    // Reset during data bit 3 of 0x55; line released high with the reset.
    base = vcount;
    hold(1'b0, Cpb);
    hold(1'b1, Cpb);
    hold(1'b0, Cpb);
    hold(1'b1, Cpb);
    hold(1'b0, 2);
    rst_n = 1'b0;
    bus.serial_in = 1'b1;
    @(negedge clk);
    check("mrst_data", bus.data_out, 8'h00);
    check("mrst_valid", bus.data_valid, 1'b0);
    check("mrst_ferr", bus.frame_error, 1'b0);
    check("mrst_perr", bus.parity_error, 1'b0);
    check("mrst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 8);
    check("mrst_no_pulse", vcount - base, 0);
    send_frame(8'h12, 1'b0, 1'b1);
    hold(1'b1, 6);
    check("x12_pulses", vcount - base, 1);
    check("x12_data", cap_data[base], 8'h12);
    check("x12_errs", {cap_perr[base], cap_ferr[base]}, 2'b00);

    // One-cycle low glitch on an idle line.
    base = vcount;
    busy_cycles = 0;
    bus.serial_in = 1'b0;
    @(negedge clk);
    bus.serial_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
    end
    check("glt_busy_seen", busy_cycles > 0, 1'b1);
    check("glt_busy_short", busy_cycles < 4, 1'b1);
    check("glt_no_pulse", vcount - base, 0);
    check("glt_idle", bus.busy, 1'b0);

    // 0xFF then 0x00 with no idle bit between them.
    base = vcount;
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    hold(1'b1, 6);
    check("b2b_pulses", vcount - base, 2);
    check("b2b_data0", cap_data[base], 8'hFF);
    check("b2b_data1", cap_data[base+1], 8'h00);
    check("b2b_errs0", {cap_perr[base], cap_ferr[base]}, 2'b00);
    check("b2b_errs1", {cap_perr[base+1], cap_ferr[base+1]}, 2'b00);
    check("b2b_busy", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
